// File: rtl/cpu_pkg.sv
// Shared types and encodings for the RISC controller: FSM states, instruction
// classes, opcode fields, register-file write mux codes and ALU operations.
package cpu_pkg;

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_WRITE_IMM,
        S_GET_A,
        S_GET_B,
        S_ALU,
        S_WRITE_REG
    } ctrl_state_t;

    typedef enum logic [2:0] {
        IC_MOV_IMM,
        IC_MOV_REG,
        IC_ALU2,
        IC_CMP,
        IC_UNARY,
        IC_ILLEGAL
    } instr_class_t;

    localparam logic [2:0] OPC_MOV    = 3'b110;
    localparam logic [2:0] OPC_ALU    = 3'b101;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;

    localparam logic [1:0] VSEL_MDATA = 2'b00;
    localparam logic [1:0] VSEL_IMM8  = 2'b01;
    localparam logic [1:0] VSEL_PC    = 2'b10;
    localparam logic [1:0] VSEL_C     = 2'b11;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_MVN = 2'b11;

    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

    function automatic logic [15:0] sext5(input logic [4:0] v);
        return {{11{v[4]}}, v};
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decode: splits the IR into its fields, produces the
// sign-extended immediates and classifies the instruction for the sequencer.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [15:0]  ir,
    output logic [1:0]   op,
    output logic [2:0]   rn,
    output logic [2:0]   rd,
    output logic [1:0]   sh,
    output logic [2:0]   rm,
    output logic [15:0]  sximm8,
    output logic [15:0]  sximm5,
    output instr_class_t iclass
);

    logic [2:0] opcode;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];
    assign sximm8 = sext8(ir[7:0]);
    assign sximm5 = sext5(ir[4:0]);

    always_comb begin
        iclass = IC_ILLEGAL;
        case (opcode)
            OPC_MOV: begin
                if (op == OP_MOV_IMM)
                    iclass = IC_MOV_IMM;
                else if (op == OP_MOV_REG)
                    iclass = IC_MOV_REG;
            end
            OPC_ALU: begin
                case (op)
                    ALU_ADD, ALU_AND: iclass = IC_ALU2;
                    ALU_SUB:          iclass = IC_CMP;
                    default:          iclass = IC_UNARY;
                endcase
            end
            default: iclass = IC_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/cpu_controller.sv
// Instruction register plus control sequencer for the datapath; one instruction
// at a time, w high while idle in WAIT.
//
// state       | meaning
// S_WAIT      | idle, accepts load/s
// S_DECODE    | IR stable, choose path by instruction class
// S_WRITE_IMM | write sximm8 into Rn
// S_GET_A     | read Rn into A
// S_GET_B     | read Rm into B
// S_ALU       | compute into C (or status for CMP)
// S_WRITE_REG | write C into Rd
module cpu_controller
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] in,
    input  logic        load,
    input  logic        s,
    output logic        w,
    output logic [1:0]  vsel,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5
);

    ctrl_state_t  state, state_nxt;
    logic [15:0]  ir;
    logic [1:0]   op, sh;
    logic [2:0]   rn, rd, rm;
    instr_class_t iclass;

    instr_decoder u_dec (
        .ir     (ir),
        .op     (op),
        .rn     (rn),
        .rd     (rd),
        .sh     (sh),
        .rm     (rm),
        .sximm8 (sximm8),
        .sximm5 (sximm5),
        .iclass (iclass)
    );

    // IR only moves in WAIT so the fields stay stable for the whole instruction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_WAIT;
            ir    <= 16'h0000;
        end else begin
            state <= state_nxt;
            if (state == S_WAIT && load)
                ir <= in;
        end
    end

    always_comb begin
        state_nxt = state;
        vsel      = VSEL_MDATA;
        readnum   = 3'd0;
        writenum  = 3'd0;
        write     = 1'b0;
        loada     = 1'b0;
        loadb     = 1'b0;
        loadc     = 1'b0;
        loads     = 1'b0;
        asel      = 1'b0;
        shift     = 2'b00;
        case (state)
            S_WAIT: begin
                if (s)
                    state_nxt = S_DECODE;
            end
            S_DECODE: begin
                case (iclass)
                    IC_MOV_IMM:          state_nxt = S_WRITE_IMM;
                    IC_ALU2, IC_CMP:     state_nxt = S_GET_A;
                    IC_MOV_REG, IC_UNARY: state_nxt = S_GET_B;
                    default:             state_nxt = S_WAIT;
                endcase
            end
            S_WRITE_IMM: begin
                vsel      = VSEL_IMM8;
                writenum  = rn;
                write     = 1'b1;
                state_nxt = S_WAIT;
            end
            S_GET_A: begin
                readnum   = rn;
                loada     = 1'b1;
                state_nxt = S_GET_B;
            end
            S_GET_B: begin
                readnum   = rm;
                loadb     = 1'b1;
                state_nxt = S_ALU;
            end
            S_ALU: begin
                shift = sh;
                // MOV reg has no A operand; asel feeds zero so the ALU passes B through.
                asel  = (iclass == IC_MOV_REG);
                if (iclass == IC_CMP) begin
                    loads     = 1'b1;
                    state_nxt = S_WAIT;
                end else begin
                    loadc     = 1'b1;
                    state_nxt = S_WRITE_REG;
                end
            end
            S_WRITE_REG: begin
                vsel      = VSEL_C;
                writenum  = rd;
                write     = 1'b1;
                state_nxt = S_WAIT;
            end
            default: state_nxt = S_WAIT;
        endcase
    end

    assign w     = (state == S_WAIT);
    assign bsel  = 1'b0;
    assign ALUop = op;

endmodule
